// File: rtl/rmt_dest_demux.sv
// Routes classified AXI-Stream frames to one of M_COUNT ports by first-beat tdest.
// Frames with an out-of-range tdest are discarded whole; per-port statistics are kept.
module rmt_dest_demux #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 2,
  parameter int M_COUNT    = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]           s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [USER_WIDTH-1:0]           s_axis_tuser,
  input  logic [DEST_WIDTH-1:0]           s_axis_tdest,
  output logic [M_COUNT*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [M_COUNT-1:0]              m_axis_tvalid,
  input  logic [M_COUNT-1:0]              m_axis_tready,
  output logic [M_COUNT-1:0]              m_axis_tlast,
  output logic [M_COUNT*USER_WIDTH-1:0]   m_axis_tuser,
  output logic [M_COUNT*CNT_WIDTH-1:0]    fwd_count,
  output logic [CNT_WIDTH-1:0]            drop_count,
  output logic [1:0]                      o_dbg_state
);

  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SEL_W-1:0]      r_sel;
  logic [SEL_W-1:0]      w_beat_sel;
  logic                  w_acc;
  logic                  w_in_range;
  logic                  w_fwd_beat;
  logic                  w_drop_done;
  logic                  w_latch_sel;

  logic                  r_s_ready;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [KEEP_WIDTH-1:0] r_out_keep;
  logic [USER_WIDTH-1:0] r_out_user;
  logic                  r_out_last;
  logic [SEL_W-1:0]      r_out_sel;
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [KEEP_WIDTH-1:0] r_skid_keep;
  logic [USER_WIDTH-1:0] r_skid_user;
  logic                  r_skid_last;
  logic [SEL_W-1:0]      r_skid_sel;
  logic                  w_out_pop;
  logic                  w_out_free;
  logic                  w_skid_valid_next;

  logic [CNT_WIDTH-1:0]  r_fwd [M_COUNT];
  logic [CNT_WIDTH-1:0]  r_drop;

  // Handshake: a beat transfers on a port in any cycle where valid and ready are both
  // high; s_axis_tready is a register (skid empty) and never depends on m_axis_tready.
  assign s_axis_tready = r_s_ready;
  assign w_acc         = s_axis_tvalid && r_s_ready;
  assign w_in_range    = 32'(s_axis_tdest) < 32'(M_COUNT);
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc && !s_axis_tlast) begin
          w_state_next = w_in_range ? S_FWD : S_DROP;
        end
      end
      S_FWD, S_DROP: begin
        if (w_acc && s_axis_tlast) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_fwd_beat  = 1'b0;
    w_drop_done = 1'b0;
    w_latch_sel = 1'b0;
    w_beat_sel  = r_sel;
    case (r_state)
      S_IDLE: begin
        w_beat_sel  = s_axis_tdest[SEL_W-1:0];
        w_fwd_beat  = w_acc && w_in_range;
        w_latch_sel = w_acc && w_in_range;
        w_drop_done = w_acc && !w_in_range && s_axis_tlast;
      end
      S_FWD:   w_fwd_beat  = w_acc;
      S_DROP:  w_drop_done = w_acc && s_axis_tlast;
      default: w_fwd_beat  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= '0;
    end else if (w_latch_sel) begin
      r_sel <= s_axis_tdest[SEL_W-1:0];
    end
  end

  assign w_out_pop         = |(m_axis_tvalid & m_axis_tready);
  assign w_out_free        = !r_out_valid || w_out_pop;
  // Skid never fills while full because s_axis_tready is already low then.
  assign w_skid_valid_next = !w_out_free && (r_skid_valid || w_fwd_beat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_ready    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_s_ready    <= !w_skid_valid_next;
      r_skid_valid <= w_skid_valid_next;
      if (w_out_free) begin
        r_out_valid <= r_skid_valid || w_fwd_beat;
      end
    end
  end

  // Payload registers carry their own port select so a new frame's sel_reg cannot disturb them.
  always_ff @(posedge clk) begin
    if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_data <= r_skid_data;
        r_out_keep <= r_skid_keep;
        r_out_user <= r_skid_user;
        r_out_last <= r_skid_last;
        r_out_sel  <= r_skid_sel;
      end else if (w_fwd_beat) begin
        r_out_data <= s_axis_tdata;
        r_out_keep <= s_axis_tkeep;
        r_out_user <= s_axis_tuser;
        r_out_last <= s_axis_tlast;
        r_out_sel  <= w_beat_sel;
      end
    end else if (w_fwd_beat) begin
      r_skid_data <= s_axis_tdata;
      r_skid_keep <= s_axis_tkeep;
      r_skid_user <= s_axis_tuser;
      r_skid_last <= s_axis_tlast;
      r_skid_sel  <= w_beat_sel;
    end
  end

  for (genvar p = 0; p < M_COUNT; p++) begin : g_port
    assign m_axis_tvalid[p] = r_out_valid && (r_out_sel == SEL_W'(p));
    assign m_axis_tlast[p]  = r_out_valid && r_out_last && (r_out_sel == SEL_W'(p));
    assign m_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH] = r_out_data;
    assign m_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH] = r_out_keep;
    assign m_axis_tuser[p*USER_WIDTH +: USER_WIDTH] = r_out_user;
    assign fwd_count[p*CNT_WIDTH +: CNT_WIDTH]      = r_fwd[p];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_fwd[p] <= '0;
      end else if (m_axis_tvalid[p] && m_axis_tready[p] && m_axis_tlast[p]) begin
        r_fwd[p] <= r_fwd[p] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop_done) begin
      r_drop <= r_drop + CNT_WIDTH'(1);
    end
  end

  assign drop_count = r_drop;

endmodule

// File: tb/tb_rmt_dest_demux.sv
// Directed bench for rmt_dest_demux: routing, drops, back-pressure, mid-frame reset.
module tb_rmt_dest_demux;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 1;
  localparam int TW = 2;
  localparam int MC = 2;
  localparam int CW = 32;

  logic           clk;
  logic           rst;
  logic [DW-1:0]  s_axis_tdata;
  logic [KW-1:0]  s_axis_tkeep;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic           s_axis_tlast;
  logic [UW-1:0]  s_axis_tuser;
  logic [TW-1:0]  s_axis_tdest;
  logic [MC*DW-1:0] m_axis_tdata;
  logic [MC*KW-1:0] m_axis_tkeep;
  logic [MC-1:0]  m_axis_tvalid;
  logic [MC-1:0]  m_axis_tready;
  logic [MC-1:0]  m_axis_tlast;
  logic [MC*UW-1:0] m_axis_tuser;
  logic [MC*CW-1:0] fwd_count;
  logic [CW-1:0]  drop_count;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  rmt_dest_demux #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
    .DEST_WIDTH(TW), .M_COUNT(MC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tdest(s_axis_tdest),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .fwd_count(fwd_count), .drop_count(drop_count),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [TW-1:0] dest,
                            input logic last, input logic [KW-1:0] keep,
                            input logic [UW-1:0] user);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tdest  = dest;
    s_axis_tlast  = last;
    s_axis_tkeep  = keep;
    s_axis_tuser  = user;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 2'b11;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    s_axis_tuser = '0; s_axis_tdest = '0;
    m_axis_tready = 2'b11;
    tick();
    tick();
    n_checks++;
    if (m_axis_tvalid !== 2'b00) begin
      n_fail++; $display("FAIL reset_tvalid: got %b want 00", m_axis_tvalid);
    end
    n_checks++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_tready: got %b want 0", s_axis_tready);
    end
    n_checks++;
    if (fwd_count !== 64'd0 || drop_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_counts: fwd %h drop %h want 0", fwd_count, drop_count);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_tready: got %b want 1", s_axis_tready);
    end
  endtask

  task automatic test_three_beat();
    logic [DW-1:0] exp_d;
    logic [KW-1:0] exp_k;
    logic [UW-1:0] exp_u;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_d = 32'hA000_0000 + 32'(i);
      exp_k = 4'b1111 >> i;
      exp_u = UW'(i % 2);
      drive_beat(exp_d, 2'd1, i == 2, exp_k, exp_u);
      tick();
      n_checks++;
      if (m_axis_tvalid !== 2'b10) begin
        n_fail++; $display("FAIL three_beat_valid beat %0d: got %b want 10", i, m_axis_tvalid);
      end
      n_checks++;
      if (m_axis_tdata !== {exp_d, exp_d} || m_axis_tkeep !== {exp_k, exp_k}
          || m_axis_tuser !== {exp_u, exp_u}) begin
        n_fail++;
        $display("FAIL three_beat_payload beat %0d: data %h keep %b user %b want %h %b %b",
                 i, m_axis_tdata, m_axis_tkeep, m_axis_tuser, exp_d, exp_k, exp_u);
      end
      n_checks++;
      if (m_axis_tlast !== ((i == 2) ? 2'b10 : 2'b00)) begin
        n_fail++; $display("FAIL three_beat_last beat %0d: got %b", i, m_axis_tlast);
      end
    end
    s_axis_tvalid = 1'b0;
    tick();
    n_checks++;
    if (m_axis_tvalid !== 2'b00) begin
      n_fail++; $display("FAIL three_beat_idle: got %b want 00", m_axis_tvalid);
    end
    n_checks++;
    if (fwd_count !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL three_beat_fwd_count: got %h want 1/0", fwd_count);
    end
  endtask

  task automatic test_back_to_back();
    int dests[4] = '{0, 1, 0, 1};
    logic [DW-1:0] exp_d;
    logic [1:0]    exp_v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_d = 32'hB000_0000 + 32'(i);
      exp_v = (dests[i] == 1) ? 2'b10 : 2'b01;
      drive_beat(exp_d, TW'(dests[i]), 1'b1, 4'hF, 1'b0);
      tick();
      n_checks++;
      if (m_axis_tvalid !== exp_v || m_axis_tlast !== exp_v) begin
        n_fail++; $display("FAIL b2b_port frame %0d: valid %b last %b want %b",
                           i, m_axis_tvalid, m_axis_tlast, exp_v);
      end
      n_checks++;
      if (m_axis_tdata[DW-1:0] !== exp_d) begin
        n_fail++; $display("FAIL b2b_data frame %0d: got %h want %h", i, m_axis_tdata[DW-1:0], exp_d);
      end
    end
    s_axis_tvalid = 1'b0;
    tick();
    n_checks++;
    if (fwd_count !== {32'd2, 32'd2}) begin
      n_fail++; $display("FAIL b2b_fwd_count: got %h want 2/2", fwd_count);
    end
  endtask

  task automatic test_back_pressure();
    logic [DW:0] exp_q[$];
    logic [DW:0] exp_e;
    logic [DW-1:0] d;
    logic rdy;
    logic acc;
    logic pop;
    int sent = 0;
    int inflight = 0;
    int cyc = 0;
    logic exp_sready = 1'b1;
    do_reset();
    while ((sent < 5 || exp_q.size() > 0) && cyc < 60) begin
      rdy = (cyc % 3 == 0);
      m_axis_tready = {1'b1, rdy};
      d = 32'hD000_0000 + 32'(sent);
      if (sent < 5) drive_beat(d, 2'd0, sent == 4, 4'hF, 1'b0);
      else s_axis_tvalid = 1'b0;
      n_checks++;
      if (s_axis_tready !== exp_sready) begin
        n_fail++; $display("FAIL bp_tready cyc %0d: got %b want %b", cyc, s_axis_tready, exp_sready);
      end
      n_checks++;
      if (m_axis_tvalid !== ((inflight > 0) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL bp_tvalid cyc %0d: got %b want inflight %0d", cyc, m_axis_tvalid, inflight);
      end
      acc = s_axis_tvalid && exp_sready;
      pop = (inflight > 0) && rdy;
      if (pop) begin
        exp_e = exp_q.pop_front();
        n_checks++;
        if (m_axis_tdata[DW-1:0] !== exp_e[DW-1:0] || m_axis_tlast[0] !== exp_e[DW]) begin
          n_fail++; $display("FAIL bp_data cyc %0d: got %h/%b want %h/%b", cyc,
                             m_axis_tdata[DW-1:0], m_axis_tlast[0], exp_e[DW-1:0], exp_e[DW]);
        end
      end
      if (acc) begin
        exp_q.push_back({sent == 4, d});
        sent++;
      end
      inflight = inflight + (acc ? 1 : 0) - (pop ? 1 : 0);
      exp_sready = (inflight < 2);
      tick();
      cyc++;
    end
    n_checks++;
    if (sent != 5 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_timeout: sent %0d pending %0d after %0d cycles", sent, exp_q.size(), cyc);
    end
    n_checks++;
    if (fwd_count !== {32'd0, 32'd1}) begin
      n_fail++; $display("FAIL bp_fwd_count: got %h want 0/1", fwd_count);
    end
    m_axis_tready = 2'b11;
    s_axis_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_tdest_change();
    logic [DW-1:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_d = 32'hF000_0000 + 32'(i);
      drive_beat(exp_d, (i == 0) ? 2'd1 : 2'd0, i == 3, 4'hF, 1'b0);
      tick();
      n_checks++;
      if (m_axis_tvalid !== 2'b10 || m_axis_tdata[DW +: DW] !== exp_d) begin
        n_fail++; $display("FAIL dest_change beat %0d: valid %b data %h want 10 %h",
                           i, m_axis_tvalid, m_axis_tdata[DW +: DW], exp_d);
      end
    end
    s_axis_tvalid = 1'b0;
    tick();
    n_checks++;
    if (fwd_count !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL dest_change_fwd_count: got %h want 1/0", fwd_count);
    end
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_beat(32'hC000_0000 + 32'(i), 2'd3, i == 3, 4'hF, 1'b0);
      tick();
      n_checks++;
      if (m_axis_tvalid !== 2'b00 || s_axis_tready !== 1'b1) begin
        n_fail++; $display("FAIL drop_beat %0d: valid %b tready %b want 00 1",
                           i, m_axis_tvalid, s_axis_tready);
      end
      n_checks++;
      if (dbg_state !== ((i == 3) ? 2'd0 : 2'd2)) begin
        n_fail++; $display("FAIL drop_state beat %0d: got %0d", i, dbg_state);
      end
    end
    n_checks++;
    if (drop_count !== 32'd1) begin
      n_fail++; $display("FAIL drop_count_frame: got %0d want 1", drop_count);
    end
    drive_beat(32'hC000_0005, 2'd0, 1'b1, 4'hF, 1'b0);
    tick();
    n_checks++;
    if (m_axis_tvalid !== 2'b01 || m_axis_tdata[DW-1:0] !== 32'hC000_0005) begin
      n_fail++; $display("FAIL drop_next_frame: valid %b data %h want 01 c0000005",
                         m_axis_tvalid, m_axis_tdata[DW-1:0]);
    end
    // single-beat drop lands on the same edge the previous frame completes
    drive_beat(32'hC000_0006, 2'd2, 1'b1, 4'hF, 1'b0);
    tick();
    n_checks++;
    if (m_axis_tvalid !== 2'b00 || drop_count !== 32'd2 || fwd_count !== {32'd0, 32'd1}) begin
      n_fail++; $display("FAIL drop_and_fwd_same_cycle: valid %b drop %0d fwd %h want 00 2 0/1",
                         m_axis_tvalid, drop_count, fwd_count);
    end
    s_axis_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_mid_frame_reset();
    m_axis_tready = 2'b11;
    drive_beat(32'hE000_0000, 2'd0, 1'b0, 4'hF, 1'b0);
    tick();
    n_checks++;
    if (m_axis_tvalid !== 2'b01) begin
      n_fail++; $display("FAIL mid_rst_beat1: got %b want 01", m_axis_tvalid);
    end
    drive_beat(32'hE000_0001, 2'd0, 1'b0, 4'hF, 1'b0);
    tick();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    tick();
    n_checks++;
    if (m_axis_tvalid !== 2'b00 || s_axis_tready !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL mid_rst_outputs: valid %b tready %b state %0d want 00 0 0",
                         m_axis_tvalid, s_axis_tready, dbg_state);
    end
    n_checks++;
    if (fwd_count !== 64'd0 || drop_count !== 32'd0) begin
      n_fail++; $display("FAIL mid_rst_counts: fwd %h drop %0d want 0", fwd_count, drop_count);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_release: tready %b want 1", s_axis_tready);
    end
    drive_beat(32'hE000_0002, 2'd1, 1'b0, 4'hF, 1'b0);
    tick();
    n_checks++;
    if (m_axis_tvalid !== 2'b10 || dbg_state !== 2'd1) begin
      n_fail++; $display("FAIL mid_rst_new_frame: valid %b state %0d want 10 1", m_axis_tvalid, dbg_state);
    end
    drive_beat(32'hE000_0003, 2'd1, 1'b1, 4'hF, 1'b0);
    tick();
    n_checks++;
    if (m_axis_tvalid !== 2'b10 || m_axis_tlast !== 2'b10) begin
      n_fail++; $display("FAIL mid_rst_last: valid %b last %b want 10 10", m_axis_tvalid, m_axis_tlast);
    end
    s_axis_tvalid = 1'b0;
    tick();
    n_checks++;
    if (fwd_count !== {32'd1, 32'd0} || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL mid_rst_fwd_count: fwd %h state %0d want 1/0 0", fwd_count, dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_three_beat();
    test_back_to_back();
    test_back_pressure();
    test_tdest_change();
    test_drop();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
